// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX serializer and the RX path.
package uart_pkg;

    // Frame-level state shared by TX and RX sequencers.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Parity type select encoding.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Legal oversampling ratios; anything else falls back to 16.
    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter: counts 0..prescale-1 while a
// frame is active and pulses bit_done on the last cycle of each serial bit.
module uart_tx_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      last_tick;

    assign last_tick = (cnt_q == (prescale - PRESCALE_WIDTH'(1)));
    assign bit_done  = run && last_tick;

    // Next tick count: held at zero outside a frame, wraps at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (last_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop.
// Build option: define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      bit_done;
    logic                      last_data_bit;
    logic                      par_bit;
    logic [PRESCALE_WIDTH-1:0] presc_norm;

    assign accept        = (state_q == StIdle) && Data_Valid;
    assign last_data_bit = (idx_q == IdxW'(DATA_WIDTH - 1));
    assign par_bit       = (^data_q) ^ (par_typ_q == PAR_ODD);

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != StIdle),
        .prescale (presc_q),
        .bit_done (bit_done)
    );

`ifdef UART_TX_STOP2_EN
    // Tracks which of the two stop bits is being sent.
    logic stop_cnt_q, stop_cnt_d;

    // Stop-bit counter: toggles at each stop bit boundary, cleared elsewhere.
    always_comb begin
        stop_cnt_d = stop_cnt_q;
        if (state_q != StStop) begin
            stop_cnt_d = 1'b0;
        end else if (bit_done) begin
            stop_cnt_d = ~stop_cnt_q;
        end
    end

    // Stop-bit counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

    // Unsupported ratios are mapped to 16 so the bit period is always legal.
    always_comb begin
        presc_norm = PRESCALE_WIDTH'(PRESCALE_16);
        if (Prescale == PRESCALE_WIDTH'(PRESCALE_8) ||
            Prescale == PRESCALE_WIDTH'(PRESCALE_16) ||
            Prescale == PRESCALE_WIDTH'(PRESCALE_32)) begin
            presc_norm = Prescale;
        end
    end

    // Frame configuration is captured only at acceptance and frozen mid-frame.
    always_comb begin
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            presc_d   = presc_norm;
        end
    end

    // Data bit index: advances on each data bit boundary, zero outside DATA.
    always_comb begin
        idx_d = idx_q;
        if (state_q != StData) begin
            idx_d = '0;
        end else if (bit_done) begin
            idx_d = last_data_bit ? '0 : idx_q + IdxW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
        end else begin
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Data_Valid) state_d = StStart;
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done && last_data_bit) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_done) state_d = StStop;
            end
            StStop: begin
`ifdef UART_TX_STOP2_EN
                if (bit_done && stop_cnt_q) state_d = StIdle;
`else
                if (bit_done) state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: outputs are registered from the upcoming state so the
    // line changes on the same edge the state does.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_q[idx_d];
            StParity: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    // Registered serial line and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard testbench for uart_tx_serializer: directed frames with
// hand-written expected bit strings and busy lengths.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

`ifdef UART_TX_STOP2_EN
    localparam int STOP_EXTRA = 1;
`else
    localparam int STOP_EXTRA = 0;
`endif

    typedef struct {
        string bits;      // transmitted bits in line order, '0'/'1'
        int    p;         // cycles per bit
        int    busy_len;  // expected busy-high cycles
        int    gap;       // expected idle cycles before frame, -1 = don't care
        bit    aborted;   // frame is cut short by reset
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    uart_tx_serializer #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Appends the extra stop bit when two stop bits are built in.
    task automatic push_exp(input string bits, input int p, input int busy_len,
                            input int gap, input bit aborted);
        exp_t e;
        e.bits     = (STOP_EXTRA != 0 && !aborted) ? {bits, "1"} : bits;
        e.p        = p;
        e.busy_len = busy_len + (aborted ? 0 : STOP_EXTRA * p);
        e.gap      = gap;
        e.aborted  = aborted;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input int p, input bit pe, input bit pt);
        @(posedge clk); #1;
        P_DATA     = d;
        Prescale   = 6'(p);
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int max, input string name);
        int n = 0;
        while (busy !== level && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== level) begin
            failures++;
            $display("FAIL %s_timeout: got busy=%0b expected %0b", name, busy, level);
        end
    endtask

    // Monitor: pops an expected frame when busy rises and compares every bit.
    exp_t cur;
    bit   in_frame = 1'b0;
    int   cyc      = 0;
    int   idle_cnt = 1000;
    int   frame_no = 0;
    bit   bit_bad  = 1'b0;
    int   bad_val  = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (!in_frame) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got busy=1 expected no frame");
                end else begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    cyc = 0;
                    bit_bad = 1'b0;
                    frame_no++;
                    if (cur.gap >= 0)
                        check($sformatf("frame%0d_gap", frame_no), idle_cnt, cur.gap);
                end
                idle_cnt = 0;
            end
            if (in_frame) begin
                int bi;
                bi = cyc / cur.p;
                if (bi < cur.bits.len()) begin
                    if (TX_OUT !== (cur.bits[bi] == "1")) begin
                        bit_bad = 1'b1;
                        bad_val = int'(TX_OUT);
                    end
                    if (cyc % cur.p == cur.p - 1) begin
                        checks++;
                        if (bit_bad) begin
                            failures++;
                            $display("FAIL frame%0d_bit%0d: got %0d expected %0d",
                                     frame_no, bi, bad_val, (cur.bits[bi] == "1"));
                        end
                        bit_bad = 1'b0;
                    end
                end
                cyc++;
            end
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (!cur.aborted) begin
                    check($sformatf("frame%0d_busy_len", frame_no), cyc, cur.busy_len);
                    check($sformatf("frame%0d_idle_line", frame_no), int'(TX_OUT), 1);
                end
            end
            idle_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd16;
        #12;
        check("reset_tx_out", int'(TX_OUT), 1);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // 0xA5, P=8, no parity
        push_exp("0101001011", 8, 80, -1, 1'b0);
        send(8'hA5, 8, 1'b0, 1'b0);
        wait_busy(1'b0, 300, "f1");

        // 0xA5, P=16, even parity -> 0
        push_exp("01010010101", 16, 176, -1, 1'b0);
        send(8'hA5, 16, 1'b1, 1'b0);
        wait_busy(1'b0, 400, "f2");

        // 0xA5, P=16, odd parity -> 1
        push_exp("01010010111", 16, 176, -1, 1'b0);
        send(8'hA5, 16, 1'b1, 1'b1);
        wait_busy(1'b0, 400, "f3");

        // 0x80, P=32, even parity -> 1; config changed mid-frame
        push_exp("00000000111", 32, 352, -1, 1'b0);
        send(8'h80, 32, 1'b1, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b1;
        wait_busy(1'b0, 800, "f4");

        // Illegal prescale 20 behaves as 16
        push_exp("0110000111", 16, 160, -1, 1'b0);
        send(8'hC3, 20, 1'b0, 1'b0);
        wait_busy(1'b0, 400, "f5");

        // Back-to-back with Data_Valid held: 0x3C then 0xC3, 1-cycle gap
        push_exp("0001111001", 8, 80, -1, 1'b0);
        push_exp("0110000111", 8, 80, 1, 1'b0);
        @(posedge clk); #1;
        P_DATA     = 8'h3C;
        Prescale   = 6'd8;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        wait_busy(1'b1, 5, "b2b_start");
        P_DATA = 8'hC3;
        wait_busy(1'b0, 300, "b2b_fall");
        wait_busy(1'b1, 5, "b2b_restart");
        Data_Valid = 1'b0;
        wait_busy(1'b0, 300, "b2b_end");

        // Reset during data bit 3 of 0xF0, then a clean frame 0x0F
        push_exp("0000011111", 8, 0, -1, 1'b1);
        send(8'hF0, 8, 1'b0, 1'b0);
        repeat (34) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_tx_out", int'(TX_OUT), 1);
        check("abort_busy", int'(busy), 0);
        #2;
        rst = 1'b1;
        push_exp("0111100001", 8, 80, -1, 1'b0);
        send(8'h0F, 8, 1'b0, 1'b0);
        wait_busy(1'b0, 300, "f_after_reset");

        // 0xFF, P=8, no parity (stop length depends on build option)
        push_exp("0111111111", 8, 80, -1, 1'b0);
        send(8'hFF, 8, 1'b0, 1'b0);
        wait_busy(1'b0, 300, "f_ff");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("monitor_idle", int'(in_frame), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
